// File: rtl/decode_pkg.sv
// Shared opcode/field constants, multdiv FSM encoding and source-register helpers
// for the decode/issue stage.
package decode_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 22;
   localparam int RS_HI  = 21;
   localparam int RS_LO  = 17;
   localparam int RT_HI  = 16;
   localparam int RT_LO  = 12;
   localparam int SH_HI  = 11;
   localparam int SH_LO  = 7;
   localparam int ALU_HI = 6;
   localparam int ALU_LO = 2;
   localparam int IMM_HI = 16;
   localparam int IMM_LO = 0;

   localparam logic [31:0] NOP = 32'd0;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   // True when ins takes register r as a source; $0 is never a real dependency.
   function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
      logic rd_hit;
      logic rs_hit;
      logic rt_hit;
      logic res;
      rd_hit = (ins[RD_HI:RD_LO] == r);
      rs_hit = (ins[RS_HI:RS_LO] == r);
      rt_hit = (ins[RT_HI:RT_LO] == r);
      case (ins[OP_HI:OP_LO])
         OP_RTYPE:              res = rs_hit | rt_hit;
         OP_ADDI, OP_LW:        res = rs_hit;
         OP_SW, OP_BNE, OP_BLT: res = rd_hit | rs_hit;
         OP_JR:                 res = rd_hit;
         OP_J, OP_JAL, OP_SETX, OP_BEX: res = 1'b0;
         default:               res = 1'b0;
      endcase
      return res & (r != 5'd0);
   endfunction

   function automatic logic is_muldiv(input logic [31:0] ins);
      return (ins[OP_HI:OP_LO] == OP_RTYPE) &&
             ((ins[ALU_HI:ALU_LO] == ALU_MUL) || (ins[ALU_HI:ALU_LO] == ALU_DIV));
   endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch->decode inputs and D/X pipeline-register outputs of the decode/issue stage.
// master = fetch/execute side, slave = decode_issue.
interface decode_issue_if #(
   parameter int W = 32
);
   logic [W-1:0] insIn;
   logic [W-1:0] pcIn;
   logic [W-1:0] jIn;
   logic         flush;
   logic         stallA;
   logic         validOut;
   logic [W-1:0] insOut;
   logic [W-1:0] pcOut;
   logic [W-1:0] jOut;
   logic [4:0]   opOut;
   logic [4:0]   rdOut;
   logic [4:0]   rsOut;
   logic [4:0]   rtOut;
   logic [4:0]   shamtOut;
   logic [4:0]   aluOut;
   logic [W-1:0] immOut;
   logic         isLoad;
   logic         mdBusy;

   modport master (
      output insIn, pcIn, jIn, flush,
      input  stallA, validOut, insOut, pcOut, jOut, opOut, rdOut, rsOut,
             rtOut, shamtOut, aluOut, immOut, isLoad, mdBusy
   );

   modport slave (
      input  insIn, pcIn, jIn, flush,
      output stallA, validOut, insOut, pcOut, jOut, opOut, rdOut, rsOut,
             rtOut, shamtOut, aluOut, immOut, isLoad, mdBusy
   );
endinterface

// File: rtl/md_busy_ctr.sv
// Multdiv occupancy tracker: IDLE/BUSY FSM, down-counter and the destination
// register of the in-flight mul/div. Busy for MD_LAT cycles including the issue cycle.
module md_busy_ctr
   import decode_pkg::*;
#(
   parameter int MD_LAT = 32
)(
   input  logic       clock,
   input  logic       aclr,
   input  logic       start_i,
   input  logic [4:0] start_rd_i,
   output logic       busy_o,
   output logic [4:0] busy_rd_o
);
   localparam int CW = $clog2(MD_LAT);

   md_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    rd_q, rd_d;

   // FSM, counter and busy-rd registers
   always_ff @(posedge clock) begin
      if (aclr) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         rd_q    <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
      end
   end

   // Leave BUSY on the edge where the count reaches zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = BUSY;
               cnt_d   = CW'(MD_LAT - 1);
               rd_d    = start_rd_i;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   assign busy_o    = (state_q == BUSY);
   assign busy_rd_o = rd_q;

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: D/X register, field split, load-use and multdiv stalls, flush bubbles.
// MD_INTERLOCK_EN enables the multi-cycle multdiv interlock; otherwise mul/div are single-cycle.
module decode_issue
   import decode_pkg::*;
#(
   parameter int W = 32
`ifdef MD_INTERLOCK_EN
   , parameter int MD_LAT = 32
`endif
)(
   input  logic          clock,
   input  logic          aclr,
   decode_issue_if.slave bus
);
   logic [W-1:0] ins_q, ins_d;
   logic [W-1:0] pc_q, pc_d;
   logic [W-1:0] j_q, j_d;
   logic         valid_q, valid_d;

   logic         lu_hazard;
   logic         md_hazard;
   logic         md_busy;
   logic         stall;

   assign lu_hazard = (ins_q[OP_HI:OP_LO] == OP_LW) &&
                      (ins_q[RD_HI:RD_LO] != 5'd0) &&
                      reads_reg(bus.insIn, ins_q[RD_HI:RD_LO]);

`ifdef MD_INTERLOCK_EN
   logic       md_start;
   logic [4:0] md_rd;

   // A mul/div is issued only when it actually enters D/X
   assign md_start = ~stall & ~bus.flush & is_muldiv(bus.insIn);

   md_busy_ctr #(
      .MD_LAT (MD_LAT)
   ) u_md_busy_ctr (
      .clock      (clock),
      .aclr       (aclr),
      .start_i    (md_start),
      .start_rd_i (bus.insIn[RD_HI:RD_LO]),
      .busy_o     (md_busy),
      .busy_rd_o  (md_rd)
   );

   assign md_hazard = md_busy & (reads_reg(bus.insIn, md_rd) | is_muldiv(bus.insIn));
`else
   assign md_busy   = 1'b0;
   assign md_hazard = 1'b0;
`endif

   // Stall request; a redirect or an empty fetch slot never stalls
   always_comb begin
      if (bus.flush || (bus.insIn == NOP)) begin
         stall = 1'b0;
      end else begin
         stall = lu_hazard | md_hazard;
      end
   end

   // D/X next state: bubble on flush or stall, otherwise take the fetched instruction
   always_comb begin
      ins_d   = NOP;
      pc_d    = {W{1'b0}};
      j_d     = {W{1'b0}};
      valid_d = 1'b0;
      if (bus.flush || stall) begin
         valid_d = 1'b0;
      end else begin
         ins_d   = bus.insIn;
         pc_d    = bus.pcIn;
         j_d     = bus.jIn;
         valid_d = (bus.insIn != NOP);
      end
   end

   // D/X pipeline register
   always_ff @(posedge clock) begin
      if (aclr) begin
         ins_q   <= NOP;
         pc_q    <= {W{1'b0}};
         j_q     <= {W{1'b0}};
         valid_q <= 1'b0;
      end else begin
         ins_q   <= ins_d;
         pc_q    <= pc_d;
         j_q     <= j_d;
         valid_q <= valid_d;
      end
   end

   assign bus.stallA   = stall;
   assign bus.validOut = valid_q;
   assign bus.insOut   = ins_q;
   assign bus.pcOut    = pc_q;
   assign bus.jOut     = j_q;
   assign bus.opOut    = ins_q[OP_HI:OP_LO];
   assign bus.rdOut    = ins_q[RD_HI:RD_LO];
   assign bus.rsOut    = ins_q[RS_HI:RS_LO];
   assign bus.rtOut    = ins_q[RT_HI:RT_LO];
   assign bus.shamtOut = ins_q[SH_HI:SH_LO];
   assign bus.aluOut   = ins_q[ALU_HI:ALU_LO];
   assign bus.immOut   = {{(W - 17){ins_q[IMM_HI]}}, ins_q[IMM_HI:IMM_LO]};
   assign bus.isLoad   = (ins_q[OP_HI:OP_LO] == OP_LW);
   assign bus.mdBusy   = md_busy;

endmodule
